// File: rtl/pipe_elastic_buffer.sv
// Elastic valid/ready pipeline buffer: STAGES chained register stages with
// optional per-stage skid registers, synchronous flush and registered occupancy.
module pipe_elastic_buffer #(
    parameter  int DATA_W = 32,
    parameter  int STAGES = 2,
    parameter  int SKID   = 1,
    localparam int CAP    = STAGES * (1 + SKID),
    localparam int OCC_W  = $clog2(CAP + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [OCC_W-1:0]  occupancy
);

    logic [STAGES:0]   vld;
    logic [STAGES:0]   rdy;
    logic [STAGES-1:0] skid_v;
    logic [DATA_W-1:0] dat [STAGES+1];

    assign vld[0]    = in_valid;
    assign dat[0]    = in_data;
    assign in_ready  = rdy[0];
    assign out_valid = vld[STAGES];
    assign out_data  = dat[STAGES];

    // Skid stages cut the ready path at a register; pass stages ripple it.
    always_comb begin
        rdy         = '0;
        rdy[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (SKID != 0) rdy[k] = ~skid_v[k];
            else           rdy[k] = ~vld[k+1] | rdy[k+1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic              mv_q, mv_d;
        logic [DATA_W-1:0] md_q, md_d;

        if (SKID != 0) begin : g_skid
            logic              sv_q, sv_d;
            logic [DATA_W-1:0] sd_q, sd_d;
            logic              drain;
            logic              take;

            assign drain     = mv_q & rdy[k+1];
            assign take      = vld[k] & ~sv_q;
            assign skid_v[k] = sv_q;

            always_comb begin
                mv_d = mv_q;
                md_d = md_q;
                sv_d = sv_q;
                sd_d = sd_q;
                if (drain || !mv_q) begin
                    if (sv_q) begin
                        mv_d = 1'b1;
                        md_d = sd_q;
                        sv_d = 1'b0;
                    end else begin
                        mv_d = take;
                        if (take) md_d = dat[k];
                    end
                end else if (take) begin
                    sv_d = 1'b1;
                    sd_d = dat[k];
                end
                if (flush) begin
                    mv_d = 1'b0;
                    sv_d = 1'b0;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sv_q <= 1'b0;
                    sd_q <= '0;
                end else begin
                    sv_q <= sv_d;
                    sd_q <= sd_d;
                end
            end
        end else begin : g_pass
            assign skid_v[k] = 1'b0;

            always_comb begin
                mv_d = mv_q;
                md_d = md_q;
                if (rdy[k]) begin
                    mv_d = vld[k];
                    if (vld[k]) md_d = dat[k];
                end
                if (flush) mv_d = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                mv_q <= 1'b0;
                md_q <= '0;
            end else begin
                mv_q <= mv_d;
                md_q <= md_d;
            end
        end

        assign vld[k+1] = mv_q;
        assign dat[k+1] = md_q;
    end

    logic [OCC_W-1:0] occ_q, occ_d;
    logic             in_xfer, out_xfer;

    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;
    assign occupancy = occ_q;

    always_comb begin
        occ_d = occ_q + OCC_W'(in_xfer) - OCC_W'(out_xfer);
        if (flush) occ_d = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) occ_q <= '0;
        else      occ_q <= occ_d;
    end

endmodule
